// File: rtl/anton_neopixel_sequencer.sv
// Frame sequencer and byte-bus arbiter placed in front of the NeoPixel transmitter.
// Optional auto-refresh request generator: define NEOPIXEL_SEQ_AUTOREFRESH_EN.
module anton_neopixel_sequencer #(
    parameter int TIMEOUT_TICKS = 65535,
    parameter int REFRESH_TICKS = 116667
) (
    input  logic        clk7mhz,
    input  logic        rstn,
    input  logic        frameStart,
    input  logic [15:0] frameLen,
    input  logic        mode32,
    output logic        busy,
    output logic        frameDone,
    output logic        frameError,
    output logic [7:0]  frameCount,
    input  logic [13:0] hostAddr,
    input  logic [7:0]  hostDataIn,
    input  logic        hostWrite,
    input  logic        hostRead,
    output logic        hostGrant,
    output logic [7:0]  hostDataOut,
    input  logic        pixelsSync,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [3:0] {
        IDLE, MAX_LO, MAX_HI, INIT, RUN, WAIT_RISE, WAIT_FALL, DONE, ABORT
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] wait_cnt;
    logic [15:0]   len_q;
    logic          mode_q;
    logic          pending;
    logic          request;
    logic          start;
    logic          timed_out;
    logic          fsm_owns;
    logic [13:0]   fsm_addr;
    logic [7:0]    fsm_data;

`ifdef NEOPIXEL_SEQ_AUTOREFRESH_EN
    localparam int RW = $clog2(REFRESH_TICKS);
    logic [RW-1:0] refresh_cnt;
    logic          refresh_wrap;

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_TICKS - 1));

    always_ff @(posedge clk7mhz or negedge rstn) begin
        if (!rstn) begin
            refresh_cnt <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign request = frameStart | refresh_wrap;
`else
    assign request = frameStart;
`endif

    assign busy      = (state != IDLE);
    assign frameDone = (state == DONE);
    assign start     = (state == IDLE) & (pending | request);
    assign timed_out = (wait_cnt == TW'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_next = state;
        fsm_owns   = 1'b0;
        fsm_addr   = '0;
        fsm_data   = '0;
        case (state)
            IDLE: begin
                if (pending || request) state_next = MAX_LO;
            end
            MAX_LO: begin
                fsm_owns   = 1'b1;
                fsm_addr   = 14'h2000;
                fsm_data   = len_q[7:0];
                state_next = MAX_HI;
            end
            MAX_HI: begin
                fsm_owns   = 1'b1;
                fsm_addr   = 14'h2001;
                fsm_data   = len_q[15:8];
                state_next = INIT;
            end
            INIT: begin
                fsm_owns   = 1'b1;
                fsm_addr   = 14'h2002;
                fsm_data   = 8'h01;
                state_next = RUN;
            end
            RUN: begin
                // run=1, limit=1, loop=0, single shot
                fsm_owns   = 1'b1;
                fsm_addr   = 14'h2002;
                fsm_data   = {3'b000, mode_q, 4'b0110};
                state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (pixelsSync)     state_next = WAIT_FALL;
                else if (timed_out) state_next = ABORT;
            end
            WAIT_FALL: begin
                if (!pixelsSync)    state_next = DONE;
                else if (timed_out) state_next = ABORT;
            end
            DONE: begin
                state_next = IDLE;
            end
            ABORT: begin
                fsm_owns   = 1'b1;
                fsm_addr   = 14'h2002;
                fsm_data   = 8'h00;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk7mhz or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            pending     <= 1'b0;
            frameError  <= 1'b0;
            frameCount  <= '0;
            hostDataOut <= '0;
        end else begin
            state <= state_next;
            // Each wait state gets a fresh budget on entry
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state == WAIT_RISE || state == WAIT_FALL) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (start) begin
                len_q   <= frameLen;
                mode_q  <= mode32;
                pending <= 1'b0;
            end else if (request && busy) begin
                pending <= 1'b1;
            end
            if (start) begin
                frameError <= 1'b0;
            end else if (state == ABORT) begin
                frameError <= 1'b1;
            end
            if (state == DONE) begin
                frameCount <= frameCount + 1'b1;
            end
            if (hostGrant && hostRead && !hostWrite) begin
                hostDataOut <= busDataOut;
            end
        end
    end

    // Register writes from the host would disturb a frame in flight, so they wait for IDLE
    assign hostGrant = (hostWrite | hostRead) & ~fsm_owns & ~(busy & hostAddr[13] & hostWrite);

    always_comb begin
        busAddr   = '0;
        busDataIn = '0;
        busWrite  = 1'b0;
        busRead   = 1'b0;
        if (fsm_owns) begin
            busAddr   = fsm_addr;
            busDataIn = fsm_data;
            busWrite  = 1'b1;
        end else if (hostGrant) begin
            busAddr   = hostAddr;
            busDataIn = hostDataIn;
            busWrite  = hostWrite;
            busRead   = hostRead & ~hostWrite;
        end
    end
endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Self-checking bench for anton_neopixel_sequencer: frame vector table, bus-write
// scoreboard fed by a transmitter memory model, and multi-cycle corner sequences.
module tb_anton_neopixel_sequencer;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [15:0] len;
        logic        m32;
        int          hold;
        logic [7:0]  expLo;
        logic [7:0]  expHi;
        logic [7:0]  expRun;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        frameStart;
    logic [15:0] frameLen;
    logic        mode32;
    logic        busy;
    logic        frameDone;
    logic        frameError;
    logic [7:0]  frameCount;
    logic [13:0] hostAddr;
    logic [7:0]  hostDataIn;
    logic        hostWrite;
    logic        hostRead;
    logic        hostGrant;
    logic [7:0]  hostDataOut;
    logic        pixelsSync;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;

    logic [7:0]  mem [0:16383];
    logic [21:0] expQ [$];
    vec_t        tab [4];
    int          errors = 0;
    int          checks = 0;
    int          expCount = 0;
    int          doneSeen = 0;

    always #5 clk = ~clk;

    anton_neopixel_sequencer #(.TIMEOUT_TICKS(TIMEOUT), .REFRESH_TICKS(116667)) dut (
        .clk7mhz(clk), .rstn(rstn), .frameStart(frameStart), .frameLen(frameLen),
        .mode32(mode32), .busy(busy), .frameDone(frameDone), .frameError(frameError),
        .frameCount(frameCount), .hostAddr(hostAddr), .hostDataIn(hostDataIn),
        .hostWrite(hostWrite), .hostRead(hostRead), .hostGrant(hostGrant),
        .hostDataOut(hostDataOut), .pixelsSync(pixelsSync), .busAddr(busAddr),
        .busDataIn(busDataIn), .busWrite(busWrite), .busRead(busRead),
        .busDataOut(busDataOut)
    );

    // Transmitter byte bus model: synchronous write, combinational read
    always @(posedge clk) if (busWrite) mem[busAddr] <= busDataIn;
    assign busDataOut = mem[busAddr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [21:0] e;
        if (busWrite) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected bus write: got addr 0x%0h data 0x%0h, expected none",
                         busAddr, busDataIn);
            end else begin
                e = expQ.pop_front();
                checkOutput("bus write addr", 32'(busAddr), 32'(e[21:8]));
                checkOutput("bus write data", 32'(busDataIn), 32'(e[7:0]));
            end
        end
        if (frameDone) doneSeen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pushWrite(input logic [13:0] a, input logic [7:0] d);
        expQ.push_back({a, d});
    endtask

    function automatic logic [7:0] expRun(input logic m32);
        return m32 ? 8'h16 : 8'h06;
    endfunction

    task automatic pushFrame(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] run);
        pushWrite(14'h2000, lo);
        pushWrite(14'h2001, hi);
        pushWrite(14'h2002, 8'h01);
        pushWrite(14'h2002, run);
    endtask

    // Ends at the negedge of the MAX_LO cycle
    task automatic applyStimulus(input logic [15:0] len, input logic m32,
                                 input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] run);
        cyc();
        frameStart = 1'b1;
        frameLen   = len;
        mode32     = m32;
        pushFrame(lo, hi, run);
        smp();
        checkOutput("busy before accept", 32'(busy), 0);
        cyc();
        frameStart = 1'b0;
        smp();
        checkOutput("busy on MAX_LO", 32'(busy), 1);
        checkOutput("MAX_LO write strobe", 32'(busWrite), 1);
        checkOutput("frameError cleared on accept", 32'(frameError), 0);
    endtask

    task automatic applyModelFrame(input logic [15:0] len, input logic m32);
        applyStimulus(len, m32, len[7:0], len[15:8], expRun(m32));
    endtask

    task automatic busCycles(input int n);
        repeat (n) begin
            cyc();
            smp();
            checkOutput("FSM write strobe", 32'(busWrite), 1);
            checkOutput("no host grant while FSM owns bus", 32'(hostGrant), 0);
        end
    endtask

    // Starts in WAIT_RISE, ends at the negedge of the IDLE cycle after DONE
    task automatic finishFrame(input int hold);
        cyc();
        frameStart = 1'b0;
        pixelsSync = 1'b1;
        smp();
        checkOutput("busy in WAIT_RISE", 32'(busy), 1);
        checkOutput("bus quiet in WAIT_RISE", 32'(busWrite), 0);
        checkOutput("no grant in WAIT_RISE", 32'(hostGrant), 0);
        repeat (hold) begin
            cyc();
            smp();
        end
        cyc();
        pixelsSync = 1'b0;
        smp();
        checkOutput("frameDone before fall seen", 32'(frameDone), 0);
        cyc();
        smp();
        checkOutput("frameDone after fall", 32'(frameDone), 1);
        checkOutput("frameCount during DONE", 32'(frameCount), expCount);
        checkOutput("no grant in DONE", 32'(hostGrant), 0);
        expCount = (expCount + 1) % 256;
        cyc();
        smp();
        checkOutput("frameDone single cycle", 32'(frameDone), 0);
        checkOutput("busy after DONE", 32'(busy), 0);
        checkOutput("frameCount incremented", 32'(frameCount), expCount);
    endtask

    initial begin
        tab[0] = '{16'h0123, 1'b1, 10, 8'h23, 8'h01, 8'h16};
        tab[1] = '{16'h0000, 1'b0, 0,  8'h00, 8'h00, 8'h06};
        tab[2] = '{16'hFFFF, 1'b1, 15, 8'hFF, 8'hFF, 8'h16};
        tab[3] = '{16'h8001, 1'b0, 2,  8'h01, 8'h80, 8'h06};

        rstn = 1'b0; frameStart = 1'b0; frameLen = '0; mode32 = 1'b0;
        hostAddr = '0; hostDataIn = '0; hostWrite = 1'b0; hostRead = 1'b0; pixelsSync = 1'b0;
        repeat (2) smp();
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset frameCount", 32'(frameCount), 0);
        checkOutput("reset frameError", 32'(frameError), 0);
        checkOutput("reset busWrite", 32'(busWrite), 0);
        checkOutput("reset hostDataOut", 32'(hostDataOut), 0);
        cyc();
        rstn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(tab[i].len, tab[i].m32, tab[i].expLo, tab[i].expHi, tab[i].expRun);
            busCycles(3);
            finishFrame(tab[i].hold);
        end

        // Timeout: sixteen WAIT_RISE cycles, then ABORT
        applyModelFrame(16'h0007, 1'b0);
        pushWrite(14'h2002, 8'h00);
        busCycles(3);
        repeat (TIMEOUT) begin
            cyc();
            smp();
            checkOutput("bus quiet before timeout", 32'(busWrite), 0);
        end
        cyc();
        smp();
        checkOutput("ABORT write strobe", 32'(busWrite), 1);
        checkOutput("ABORT addr", 32'(busAddr), 'h2002);
        checkOutput("ABORT data", 32'(busDataIn), 'h00);
        checkOutput("no frameDone in ABORT", 32'(frameDone), 0);
        cyc();
        smp();
        checkOutput("frameError after timeout", 32'(frameError), 1);
        checkOutput("busy after ABORT", 32'(busy), 0);
        checkOutput("frameCount unchanged on abort", 32'(frameCount), expCount);
        checkOutput("no frameDone pulse on abort", 32'(doneSeen), expCount);

        // Host register write held from INIT stalls until the frame ends
        applyModelFrame(16'h0040, 1'b0);
        busCycles(1);
        cyc();
        hostWrite = 1'b1; hostAddr = 14'h2000; hostDataIn = 8'h55;
        pushWrite(14'h2000, 8'h55);
        smp();
        checkOutput("host reg write blocked in INIT", 32'(hostGrant), 0);
        checkOutput("FSM keeps bus in INIT", 32'(busAddr), 'h2002);
        busCycles(1);
        finishFrame(3);
        checkOutput("host reg write granted in IDLE", 32'(hostGrant), 1);
        cyc();
        hostWrite = 1'b0;

        // Host buffer access during WAIT_RISE
        applyModelFrame(16'h0003, 1'b1);
        busCycles(3);
        cyc();
        hostWrite = 1'b1; hostAddr = 14'h0005; hostDataIn = 8'hAA;
        pushWrite(14'h0005, 8'hAA);
        smp();
        checkOutput("buffer write granted in WAIT_RISE", 32'(hostGrant), 1);
        checkOutput("bus addr mirrors host", 32'(busAddr), 'h0005);
        cyc();
        hostWrite = 1'b0; hostRead = 1'b1;
        smp();
        checkOutput("buffer read granted", 32'(hostGrant), 1);
        checkOutput("busRead on host read", 32'(busRead), 1);
        cyc();
        hostWrite = 1'b1; hostAddr = 14'h0006; hostDataIn = 8'h3C;
        pushWrite(14'h0006, 8'h3C);
        smp();
        checkOutput("hostDataOut after read", 32'(hostDataOut), 'hAA);
        checkOutput("read+write treated as write", 32'(busRead), 0);
        cyc();
        hostWrite = 1'b0; hostRead = 1'b0;
        smp();
        checkOutput("hostDataOut held across write", 32'(hostDataOut), 'hAA);
        finishFrame(5);

        // Three requests while busy collapse into one extra frame
        applyModelFrame(16'h0042, 1'b0);
        pushFrame(8'h42, 8'h00, 8'h06);
        cyc(); frameStart = 1'b1; smp();
        cyc(); frameStart = 1'b0; smp();
        cyc(); frameStart = 1'b1; smp();
        cyc(); frameStart = 1'b0; smp();
        checkOutput("busy in WAIT_RISE before pulse", 32'(busy), 1);
        cyc(); frameStart = 1'b1; smp();
        finishFrame(4);
        cyc();
        smp();
        checkOutput("pending frame starts", 32'(busy), 1);
        checkOutput("pending frame MAX_LO addr", 32'(busAddr), 'h2000);
        busCycles(3);
        finishFrame(2);
        repeat (4) begin
            cyc();
            smp();
            checkOutput("no third frame", 32'(busy), 0);
        end

        // Asynchronous reset in WAIT_FALL
        applyModelFrame(16'h0010, 1'b1);
        busCycles(3);
        cyc(); pixelsSync = 1'b1; smp();
        cyc(); smp();
        checkOutput("busy in WAIT_FALL", 32'(busy), 1);
        cyc();
        rstn = 1'b0;
        #1;
        checkOutput("reset: busy", 32'(busy), 0);
        checkOutput("reset: frameDone", 32'(frameDone), 0);
        checkOutput("reset: frameError", 32'(frameError), 0);
        checkOutput("reset: frameCount", 32'(frameCount), 0);
        checkOutput("reset: hostGrant", 32'(hostGrant), 0);
        checkOutput("reset: hostDataOut", 32'(hostDataOut), 0);
        checkOutput("reset: bus outputs", 32'({busWrite, busRead, busAddr, busDataIn}), 0);
        pixelsSync = 1'b0;
        cyc();
        rstn = 1'b1;
        smp();
        checkOutput("IDLE after reset release", 32'(busy), 0);
        cyc(); pixelsSync = 1'b1; smp();
        cyc(); pixelsSync = 1'b0; smp();
        checkOutput("no frameDone after reset", 32'(frameDone), 0);
        checkOutput("still IDLE after sync toggle", 32'(busy), 0);

        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("total frameDone pulses", doneSeen, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/anton_neopixel_sequencer.md
Name: anton_neopixel_sequencer

Overview:
Frame sequencer and bus arbiter in front of the raw NeoPixel transmitter's byte bus. It shares that bus between an external host and an internal FSM. On each frame request the FSM programs the max and ctrl registers, starts a single-shot transmission and tracks pixelsSync until the latch/reset period ends. Same clock as the transmitter: clk7mhz drives both this block and the transmitter's busClk.

Parameters:
TIMEOUT_TICKS, 65535, clk7mhz cycles allowed in each WAIT state before aborting the frame.
REFRESH_TICKS, 116667, auto-refresh period in clk7mhz cycles (~60 Hz); used only with the optional feature.

Ports:
clk7mhz  in  1  system clock; also feeds the transmitter's busClk.
rstn  in  1  asynchronous active-low reset.
frameStart  in  1  one-cycle pulse requesting one frame.
frameLen  in  16  value written to the max register; sampled at frame start.
mode32  in  1  value for the ctrl 32bit bit; sampled at frame start.
busy  out  1  high from frame accept until DONE.
frameDone  out  1  one-cycle pulse at normal frame completion.
frameError  out  1  sticky timeout flag; cleared by the next accepted frame.
frameCount  out  8  completed-frame counter; wraps 255 to 0.
hostAddr  in  14  host bus address.
hostDataIn  in  8  host write data.
hostWrite  in  1  host write request, held until granted.
hostRead  in  1  host read request, held until granted.
hostGrant  out  1  host cycle is forwarded this clock.
hostDataOut  out  8  host read data, valid 1 cycle after grant.
pixelsSync  in  1  transmitter reset-phase indicator.
busAddr  out  14  to transmitter.
busDataIn  out  8  to transmitter.
busWrite  out  1  to transmitter.
busRead  out  1  to transmitter.
busDataOut  in  8  from transmitter.

Behaviour:
- Reset (rstn low, async): FSM to IDLE; all outputs 0. The transmitter has no reset, so a transmission in flight continues.
- FSM states, one bus write per state, 1 cycle each:
  - IDLE -> MAX_LO on a frame request. MAX_LO writes addr 0x2000 = frameLen[7:0].
  - MAX_HI writes 0x2001 = frameLen[15:8].
  - INIT writes 0x2002 = 0x01 (self-clearing init).
  - RUN writes 0x2002 = {3'b0, mode32, 1'b0, 1'b1, 1'b1, 1'b0}, i.e. run=1, limit=1, loop=0.
- WAIT_RISE: wait for pixelsSync = 1, then go to WAIT_FALL.
- WAIT_FALL: wait for pixelsSync = 0, then go to DONE.
- DONE (1 cycle): frameDone=1, frameCount+1, then IDLE.
- Frame accept: frameLen and mode32 are latched on IDLE exit; frameError is cleared there. busy=1 from the MAX_LO cycle through DONE.
- Timeout: each WAIT state has its own counter, reset on state entry.
  - When the counter reaches TIMEOUT_TICKS, go to ABORT.
  - ABORT writes 0x2002 = 0x00 and sets frameError; then IDLE with no frameDone and no count increment.
- Pending requests:
  - frameStart while busy sets a one-deep pending flag. Extra pulses while the flag is set are dropped.
  - The pending frame starts on the cycle after DONE/ABORT, so IDLE is held for 1 cycle.
  - frameStart coincident with DONE also becomes pending.
- Arbitration (FSM has priority):
  - The FSM owns the bus in MAX_LO, MAX_HI, INIT, RUN and ABORT.
  - hostGrant = (hostWrite|hostRead) & ~fsmOwnsBus & ~(busy & hostAddr[13] & hostWrite). Host register writes stall while busy; host buffer writes and all host reads may proceed in the WAIT states.
  - On grant, bus signals mirror the host signals combinationally. hostDataOut = busDataOut registered path, valid the cycle after a granted read.
  - hostWrite and hostRead both high: treat as a write only.
  - When nothing is granted, bus outputs are 0.
- Frame request with frameLen=0 is still sequenced normally.

Optional Feature:
Macro: NEOPIXEL_SEQ_AUTOREFRESH_EN.
- Defined: a free-running counter counts 0..REFRESH_TICKS-1. On wrap it raises an internal request, ORed with frameStart, with the same pending rules.
- Undefined: no counter logic; frames start only from frameStart.

Test Plan:
- Write sequence: frameStart, frameLen=0x0123, mode32=1 -> writes 0x2000=0x23, 0x2001=0x01, 0x2002=0x01, 0x2002=0x16 on 4 consecutive cycles. busy rises on the first of these cycles.
- Normal completion: pixelsSync 0->1, held 600 cycles, then ->0 -> one frameDone pulse the cycle after the fall; frameCount 0->1; busy low after DONE.
- Timeout: TIMEOUT_TICKS=16 and pixelsSync held 0 -> ABORT write 0x2002=0x00 after 16 WAIT_RISE cycles. frameError=1, no frameDone, frameCount unchanged.
- Host arbitration, register write: host write 0x2000 during INIT -> hostGrant=0 until DONE.
- Host arbitration, buffer access: host write 0x0005=0xAA in WAIT_RISE -> granted same cycle. A following read of 0x0005 returns 0xAA on hostDataOut one cycle after grant.
- Pending and reset: three frameStart pulses while busy -> exactly one extra frame, starting 1 cycle after DONE. Asserting rstn in WAIT_FALL -> all outputs 0 immediately, FSM in IDLE.
